// File: rtl/freq_pkg.sv
// Shared definitions for the frequency setpoint controller.
//   NDIG        - number of BCD digits in the setpoint
//   FW          - width of the binary frequency handed to the generator
//   DIGW        - bits per BCD digit
//   DEFAULT_BCD - setpoint loaded at reset (1000 Hz)
//   state_e     - controller FSM states
//   op_e        - edit operation applied to the setpoint
package freq_pkg;

  localparam int unsigned NDIG = 6;
  localparam int unsigned FW   = 20;
  localparam int unsigned DIGW = 4;

  localparam logic [DIGW*NDIG-1:0] DEFAULT_BCD = 24'h001000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StPresent = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OpNone = 2'd0,
    OpInc  = 2'd1,
    OpDec  = 2'd2
  } op_e;

endpackage

// File: rtl/bcd_step.sv
// Combinational BCD stepper: adds or subtracts 10^k to a packed BCD value,
// where k is the index of the one-hot cursor bit.
//   value   - current BCD setpoint, digit 0 in the low nibble
//   cursor  - one-hot digit position to step
//   op      - OpInc, OpDec or OpNone
//   stepped - resulting BCD value (only meaningful when limit is low)
//   limit   - carry or borrow ran out of the most significant digit
module bcd_step import freq_pkg::*; #(
  parameter int unsigned NDIG = freq_pkg::NDIG
) (
  input  logic [DIGW*NDIG-1:0] value,
  input  logic [NDIG-1:0]      cursor,
  input  op_e                  op,
  output logic [DIGW*NDIG-1:0] stepped,
  output logic                 limit
);

  logic [DIGW-1:0] dig;
  logic            c;

  // c is the carry (increment) or borrow (decrement) entering digit i. Digits
  // below the cursor see no carry, so it is injected at the cursor position.
  always_comb begin
    stepped = value;
    dig     = '0;
    c       = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      c   = c | cursor[i];
      dig = value[DIGW*i +: DIGW];
      if (op == OpInc) begin
        if (c && (dig == DIGW'(9))) begin
          dig = '0;
        end else begin
          dig = dig + DIGW'(c);
          c   = 1'b0;
        end
      end else if (op == OpDec) begin
        if (c && (dig == '0)) begin
          dig = DIGW'(9);
        end else begin
          dig = dig - DIGW'(c);
          c   = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
      stepped[DIGW*i +: DIGW] = dig;
    end
    limit = c;
  end

endmodule

// File: rtl/freq_set_ctrl.sv
// Front-panel frequency setpoint controller. Holds a BCD setpoint edited by
// single-cycle key pulses, and converts it to binary for the generator over a
// valid/ready handshake so the generator never sees a half-updated value.
//   clk, rst_n  - clock, asynchronous active-low reset
//   inc_p/dec_p - add/subtract 1 at the cursor digit (both at once: ignored)
//   sel_p       - rotate cursor one digit toward the MSD, wrapping
//   digits      - live BCD setpoint, digit 0 in bits [3:0]
//   cursor      - one-hot cursor position
//   freq_bin    - converted setpoint, stable while freq_valid is high
//   freq_valid  - freq_bin offered to the generator
//   freq_ready  - generator accepts freq_bin
//   busy        - converting or presenting
module freq_set_ctrl import freq_pkg::*; #(
  parameter int unsigned           NDIG        = freq_pkg::NDIG,
  parameter int unsigned           FW          = freq_pkg::FW,
  parameter logic [DIGW*NDIG-1:0]  DEFAULT_BCD = freq_pkg::DEFAULT_BCD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_p,
  input  logic                 dec_p,
  input  logic                 sel_p,
  output logic [DIGW*NDIG-1:0] digits,
  output logic [NDIG-1:0]      cursor,
  output logic [FW-1:0]        freq_bin,
  output logic                 freq_valid,
  input  logic                 freq_ready,
  output logic                 busy
);

  state_e                state_q, state_d;
  logic [DIGW*NDIG-1:0]  digits_q;
  logic [NDIG-1:0]       cursor_q;
  logic                  dirty_q;
  logic [DIGW*NDIG-1:0]  snap_q;
  logic [FW-1:0]         acc_q;
  logic [2:0]            cnt_q;
  logic [FW-1:0]         freq_bin_q;

  op_e                   op;
  logic [DIGW*NDIG-1:0]  stepped;
  logic                  limit;
  logic                  edit_ok;
  logic                  snap_load;
  logic                  conv_done;
  logic [FW-1:0]         acc_next;

  // ---------------------------------------------------------------------------
  // Setpoint editing
  // ---------------------------------------------------------------------------
  always_comb begin
    op = OpNone;
    if (inc_p && !dec_p) begin
      op = OpInc;
    end else if (dec_p && !inc_p) begin
      op = OpDec;
    end
  end

  bcd_step #(
    .NDIG (NDIG)
  ) u_bcd_step (
    .value   (digits_q),
    .cursor  (cursor_q),
    .op      (op),
    .stepped (stepped),
    .limit   (limit)
  );

  // Saturating edits leave the value untouched; any accepted step is a change.
  assign edit_ok = (op != OpNone) && !limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= DEFAULT_BCD;
      cursor_q <= NDIG'(1);
    end else begin
      if (edit_ok) begin
        digits_q <= stepped;
      end
      if (sel_p) begin
        cursor_q <= {cursor_q[NDIG-2:0], cursor_q[NDIG-1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    conv_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (dirty_q) begin
          state_d   = StConvert;
          snap_load = 1'b1;
        end
      end
      StConvert: begin
        if (cnt_q == 3'd1) begin
          state_d   = StPresent;
          conv_done = 1'b1;
        end
      end
      StPresent: begin
        if (freq_ready) begin
          if (dirty_q) begin
            state_d   = StConvert;
            snap_load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    freq_valid = (state_q == StPresent);
    busy       = (state_q != StIdle);
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath: MSD-first Horner evaluation, acc*10 as two shifts.
  // ---------------------------------------------------------------------------
  assign acc_next = (acc_q << 3) + (acc_q << 1) + FW'(snap_q[DIGW*NDIG-1 -: DIGW]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= 1'b1;
    end else if (edit_ok) begin
      // An edit in the snapshot cycle postdates the snapshot, so it stays dirty.
      dirty_q <= 1'b1;
    end else if (snap_load) begin
      dirty_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (snap_load) begin
      snap_q <= digits_q;
      acc_q  <= '0;
      cnt_q  <= 3'(NDIG);
    end else if (state_q == StConvert) begin
      snap_q <= snap_q << DIGW;
      acc_q  <= acc_next;
      cnt_q  <= cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_bin_q <= '0;
    end else if (conv_done) begin
      freq_bin_q <= acc_next;
    end
  end

  assign digits   = digits_q;
  assign cursor   = cursor_q;
  assign freq_bin = freq_bin_q;

endmodule

// File: tb/tb_freq_set_ctrl.sv
// Scoreboard bench for freq_set_ctrl. The reference model keeps the setpoint
// as an integer and the cursor as a digit index; every accepted handshake is
// compared against the queue of values the model says must be presented.
module tb_freq_set_ctrl;

  localparam int unsigned NDIG = 6;
  localparam int unsigned FW   = 20;
  localparam int          VMAX = 999999;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inc_p = 1'b0;
  logic              dec_p = 1'b0;
  logic              sel_p = 1'b0;
  logic              freq_ready = 1'b1;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   cursor;
  logic [FW-1:0]     freq_bin;
  logic              freq_valid;
  logic              busy;

  freq_set_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_p      (inc_p),
    .dec_p      (dec_p),
    .sel_p      (sel_p),
    .digits     (digits),
    .cursor     (cursor),
    .freq_bin   (freq_bin),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned exp_q[$];
  bit          loose = 1'b0;  // edits coalesce: skip per-handshake value checks
  int          model_val = 1000;
  int          model_cur = 0;

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes against the scoreboard, plus the hold rule.
  logic          prev_hold = 1'b0;
  logic [FW-1:0] prev_bin = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("valid_held", longint'(freq_valid), 1);
        check("bin_held", longint'(freq_bin), longint'(prev_bin));
      end
      if (freq_valid && freq_ready && !loose) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_present: got freq_bin=%0d required no handshake", freq_bin);
        end else begin
          check("freq_bin", longint'(freq_bin), longint'(exp_q.pop_front()));
        end
      end
      prev_hold <= freq_valid && !freq_ready;
      prev_bin  <= freq_bin;
    end
  end

  // One edit cycle; model applies the edit at the old cursor, then moves it.
  task automatic do_op(input bit inc, input bit dec, input bit sel, output bit changed);
    int p = p10(model_cur);
    changed = 1'b0;
    inc_p = inc;
    dec_p = dec;
    sel_p = sel;
    step();
    inc_p = 1'b0;
    dec_p = 1'b0;
    sel_p = 1'b0;
    if (inc && !dec && (model_val + p <= VMAX)) begin
      model_val += p;
      changed = 1'b1;
    end else if (dec && !inc && (model_val - p >= 0)) begin
      model_val -= p;
      changed = 1'b1;
    end
    if (sel) model_cur = (model_cur + 1) % NDIG;
    if (changed && !loose) exp_q.push_back(model_val);
    check("digits", longint'(digits), longint'(to_bcd(model_val)));
    check("cursor", longint'(cursor), longint'(1 << model_cur));
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n = 0;
    repeat (3) step();
    while (busy && n < 300) begin
      if (rand_ready) freq_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    freq_ready = 1'b1;
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy=%0d required 0", busy);
    end
  endtask

  task automatic expect_quiet(input string name);
    for (int i = 0; i < 3; i++) begin
      step();
      check(name, longint'(busy), 0);
    end
  endtask

  task automatic move_cursor(input int k);
    bit ch;
    while (model_cur != k) do_op(1'b0, 1'b0, 1'b1, ch);
  endtask

  // Walk each digit to the target without ripple; final value must be presented.
  task automatic set_value(input int target);
    bit ch;
    loose = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      move_cursor(k);
      while ((model_val / p10(k)) % 10 < (target / p10(k)) % 10) do_op(1'b1, 1'b0, 1'b0, ch);
      while ((model_val / p10(k)) % 10 > (target / p10(k)) % 10) do_op(1'b0, 1'b1, 1'b0, ch);
    end
    wait_idle(1'b0);
    loose = 1'b0;
    check("set_value_bin", longint'(freq_bin), longint'(target));
  endtask

  initial begin
    bit ch;
    int cyc;
    int r;

    // Reset values, then the default setpoint is presented on its own.
    repeat (2) step();
    check("rst_digits", longint'(digits), 64'h001000);
    check("rst_cursor", longint'(cursor), 1);
    check("rst_freq_bin", longint'(freq_bin), 0);
    check("rst_valid", longint'(freq_valid), 0);
    check("rst_busy", longint'(busy), 0);
    exp_q.push_back(1000);
    rst_n = 1'b1;
    wait_idle(1'b0);
    check("boot_bin", longint'(freq_bin), 1000);
    check("boot_idle", longint'(busy), 0);

    // 000999 + 1 at digit 0 ripples to 001000, valid exactly 8 cycles later.
    do_op(1'b0, 1'b1, 1'b0, ch);
    wait_idle(1'b0);
    do_op(1'b1, 1'b0, 1'b0, ch);
    cyc = 1;
    while (!freq_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("latency", longint'(cyc), 8);
    wait_idle(1'b0);

    // Simultaneous inc/dec ignored; six selects bring the cursor home.
    do_op(1'b1, 1'b1, 1'b0, ch);
    expect_quiet("incdec_busy");
    for (int i = 0; i < NDIG; i++) do_op(1'b0, 1'b0, 1'b1, ch);
    check("cursor_wrap", longint'(cursor), 1);

    // Underflow: 000500 minus 1000 is refused.
    set_value(500);
    move_cursor(3);
    do_op(1'b0, 1'b1, 1'b0, ch);
    expect_quiet("underflow_busy");

    // Saturation: 999999 plus anything is refused.
    set_value(VMAX);
    move_cursor(int'($urandom_range(0, NDIG - 1)));
    do_op(1'b1, 1'b0, 1'b0, ch);
    expect_quiet("saturate_busy");

    // sel x4 then inc on 001000 gives 011000.
    set_value(1000);
    move_cursor(0);
    for (int i = 0; i < 4; i++) do_op(1'b0, 1'b0, 1'b1, ch);
    do_op(1'b1, 1'b0, 1'b0, ch);
    wait_idle(1'b0);
    check("sel4_bin", longint'(freq_bin), 11000);

    // Generator stalls: the presented value must hold while the setpoint moves.
    set_value(999);
    move_cursor(0);
    freq_ready = 1'b0;
    do_op(1'b1, 1'b0, 1'b0, ch);
    cyc = 0;
    while (!freq_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("stall_valid", longint'(freq_valid), 1);
    check("stall_bin", longint'(freq_bin), 1000);
    do_op(1'b1, 1'b0, 1'b0, ch);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_hold_valid", longint'(freq_valid), 1);
      check("stall_hold_bin", longint'(freq_bin), 1000);
    end
    freq_ready = 1'b1;
    wait_idle(1'b0);
    check("stall_final_bin", longint'(freq_bin), 1001);
    check("stall_queue", longint'(exp_q.size()), 0);

    // Reset in the third CONVERT cycle discards the conversion.
    do_op(1'b1, 1'b0, 1'b0, ch);
    repeat (3) step();
    check("midconv_busy", longint'(busy), 1);
    rst_n = 1'b0;
    step();
    check("mrst_digits", longint'(digits), 64'h001000);
    check("mrst_cursor", longint'(cursor), 1);
    check("mrst_freq_bin", longint'(freq_bin), 0);
    check("mrst_valid", longint'(freq_valid), 0);
    check("mrst_busy", longint'(busy), 0);
    exp_q.delete();
    model_val = 1000;
    model_cur = 0;
    exp_q.push_back(1000);
    rst_n = 1'b1;
    wait_idle(1'b0);
    check("mrst_boot_bin", longint'(freq_bin), 1000);

    // Random edits with a randomly stalling generator.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      do_op(r >= 3 && r <= 5 || r == 9, r >= 6, r < 3 || $urandom_range(0, 3) == 0, ch);
      if (ch) wait_idle(1'b1);
      else expect_quiet("rand_quiet");
    end
    wait_idle(1'b0);
    check("rand_final_bin", longint'(freq_bin), longint'(model_val));
    check("final_queue", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
